// File: rtl/cpu_ctrl_pkg.sv
// rtl/cpu_ctrl_pkg.sv - shared encodings for the multi-cycle RV32I sequencer
package cpu_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_FETCH     = 3'd0,
        ST_DECODE    = 3'd1,
        ST_EXECUTE   = 3'd2,
        ST_MEMORY    = 3'd3,
        ST_WRITEBACK = 3'd4,
        ST_TRAP      = 3'd5
    } state_t;

    typedef enum logic [3:0] {
        CLS_R,
        CLS_I,
        CLS_LOAD,
        CLS_STORE,
        CLS_BRANCH,
        CLS_JALR,
        CLS_JAL,
        CLS_AUIPC,
        CLS_LUI,
        CLS_ILLEGAL
    } instr_class_t;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;

    localparam logic [1:0] PC_PLUS4  = 2'd0;
    localparam logic [1:0] PC_TARGET = 2'd1;
    localparam logic [1:0] PC_JALR   = 2'd2;

    function automatic instr_class_t decode_class(input logic [6:0] op);
        case (op)
            OP_R:      return CLS_R;
            OP_I:      return CLS_I;
            OP_LOAD:   return CLS_LOAD;
            OP_STORE:  return CLS_STORE;
            OP_BRANCH: return CLS_BRANCH;
            OP_JALR:   return CLS_JALR;
            OP_JAL:    return CLS_JAL;
            OP_AUIPC:  return CLS_AUIPC;
            OP_LUI:    return CLS_LUI;
            default:   return CLS_ILLEGAL;
        endcase
    endfunction

endpackage

// File: rtl/perf_counters.sv
// rtl/perf_counters.sv - wrapping cycle and retired-instruction counters
module perf_counters #(
    parameter int CNT_WIDTH = 32
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 count_en,
    input  logic                 retire,
    output logic [CNT_WIDTH-1:0] cycle_count,
    output logic [CNT_WIDTH-1:0] instret_count
);

    // Both counters wrap naturally and hold while count_en is low (trapped core).
    always_ff @(posedge clock) begin
        if (reset) begin
            cycle_count   <= '0;
            instret_count <= '0;
        end else if (count_en) begin
            cycle_count <= cycle_count + CNT_WIDTH'(1);
            if (retire) begin
                instret_count <= instret_count + CNT_WIDTH'(1);
            end
        end
    end

endmodule

// File: rtl/multicycle_ctrl.sv
// rtl/multicycle_ctrl.sv - multi-cycle RV32I sequencer FSM with bus timeout; PERF_COUNTERS_EN adds perf counters
module multicycle_ctrl
    import cpu_ctrl_pkg::*;
#(
    parameter int MEM_TIMEOUT = 16,
    parameter int CNT_WIDTH   = 32
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic [6:0]           opcode,
    input  logic                 dec_write_enable,
    input  logic                 dec_branch,
    input  logic                 branch_taken,
    input  logic                 imem_ready,
    input  logic                 dmem_ready,
    output logic                 imem_req,
    output logic                 ir_load,
    output logic                 dmem_req,
    output logic                 dmem_rw,
    output logic                 regfile_we,
    output logic                 pc_write,
    output logic [1:0]           pc_sel,
    output logic [2:0]           state,
    output logic                 illegal_instr,
    output logic                 bus_error,
    output logic [CNT_WIDTH-1:0] cycle_count,
    output logic [CNT_WIDTH-1:0] instret_count
);

    // The wait counter only has to count up to MEM_TIMEOUT-1.
    localparam int WAIT_W = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;

    state_t             state_q;
    state_t             state_next;
    instr_class_t       cls_q;
    logic               we_q;
    logic               br_q;
    logic [WAIT_W-1:0]  wait_q;
    logic               waiting;
    logic               timeout_hit;
    logic               set_illegal;
    logic               set_bus_err;
    logic               illegal_q;
    logic               bus_err_q;

    assign state         = state_q;
    assign illegal_instr = illegal_q;
    assign bus_error     = bus_err_q;

    assign waiting = ((state_q == ST_FETCH)  && !imem_ready) ||
                     ((state_q == ST_MEMORY) && !dmem_ready);

    // Trap on the MEM_TIMEOUT-th consecutive cycle without ready; ready in that cycle still wins.
    generate
        if (MEM_TIMEOUT != 0) begin : g_timeout
            assign timeout_hit = (wait_q == WAIT_W'(MEM_TIMEOUT - 1));
        end else begin : g_no_timeout
            assign timeout_hit = 1'b0;
        end
    endgenerate

    // State register.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= ST_FETCH;
        end else begin
            state_q <= state_next;
        end
    end

    // Latch instruction class and decoder flags while the IR is decoded.
    always_ff @(posedge clock) begin
        if (reset) begin
            cls_q <= CLS_R;
            we_q  <= 1'b0;
            br_q  <= 1'b0;
        end else if (state_q == ST_DECODE) begin
            cls_q <= decode_class(opcode);
            we_q  <= dec_write_enable;
            br_q  <= dec_branch;
        end
    end

    // Wait counter restarts on every state change and counts cycles stalled on ready.
    always_ff @(posedge clock) begin
        if (reset) begin
            wait_q <= '0;
        end else if (state_next != state_q) begin
            wait_q <= '0;
        end else if (waiting) begin
            wait_q <= wait_q + WAIT_W'(1);
        end
    end

    // Sticky trap causes, cleared only by reset.
    always_ff @(posedge clock) begin
        if (reset) begin
            illegal_q <= 1'b0;
            bus_err_q <= 1'b0;
        end else begin
            if (set_illegal) begin
                illegal_q <= 1'b1;
            end
            if (set_bus_err) begin
                bus_err_q <= 1'b1;
            end
        end
    end

    // Next-state and strobe decode; everything is held low while reset is asserted.
    always_comb begin
        state_next  = state_q;
        imem_req    = 1'b0;
        ir_load     = 1'b0;
        dmem_req    = 1'b0;
        dmem_rw     = 1'b0;
        regfile_we  = 1'b0;
        pc_write    = 1'b0;
        pc_sel      = PC_PLUS4;
        set_illegal = 1'b0;
        set_bus_err = 1'b0;
        if (!reset) begin
            case (state_q)
                ST_FETCH: begin
                    imem_req = 1'b1;
                    if (imem_ready) begin
                        ir_load    = 1'b1;
                        state_next = ST_DECODE;
                    end else if (timeout_hit) begin
                        set_bus_err = 1'b1;
                        state_next  = ST_TRAP;
                    end
                end
                ST_DECODE: begin
                    if (decode_class(opcode) == CLS_ILLEGAL) begin
                        set_illegal = 1'b1;
                        state_next  = ST_TRAP;
                    end else begin
                        state_next = ST_EXECUTE;
                    end
                end
                ST_EXECUTE: begin
                    case (cls_q)
                        CLS_LOAD, CLS_STORE: state_next = ST_MEMORY;
                        CLS_BRANCH: begin
                            // Take the target only when the decoder also flags a branch.
                            pc_write   = 1'b1;
                            pc_sel     = (branch_taken && br_q) ? PC_TARGET : PC_PLUS4;
                            state_next = ST_FETCH;
                        end
                        default: state_next = ST_WRITEBACK;
                    endcase
                end
                ST_MEMORY: begin
                    dmem_req = 1'b1;
                    dmem_rw  = (cls_q == CLS_STORE);
                    if (dmem_ready) begin
                        if (cls_q == CLS_STORE) begin
                            pc_write   = 1'b1;
                            state_next = ST_FETCH;
                        end else begin
                            state_next = ST_WRITEBACK;
                        end
                    end else if (timeout_hit) begin
                        set_bus_err = 1'b1;
                        state_next  = ST_TRAP;
                    end
                end
                ST_WRITEBACK: begin
                    regfile_we = we_q;
                    pc_write   = 1'b1;
                    case (cls_q)
                        CLS_JAL:  pc_sel = PC_TARGET;
                        CLS_JALR: pc_sel = PC_JALR;
                        default:  pc_sel = PC_PLUS4;
                    endcase
                    state_next = ST_FETCH;
                end
                ST_TRAP: state_next = ST_TRAP;
                default: state_next = ST_TRAP;
            endcase
        end
    end

`ifdef PERF_COUNTERS_EN
    // Every retire coincides with the PC update strobe.
    perf_counters #(
        .CNT_WIDTH (CNT_WIDTH)
    ) u_perf_counters (
        .clock         (clock),
        .reset         (reset),
        .count_en      (state_q != ST_TRAP),
        .retire        (pc_write),
        .cycle_count   (cycle_count),
        .instret_count (instret_count)
    );
`else
    assign cycle_count   = '0;
    assign instret_count = '0;
`endif

endmodule

// File: tb/tb_multicycle_ctrl.sv
// tb/tb_multicycle_ctrl.sv - scoreboard bench for multicycle_ctrl
module tb_multicycle_ctrl;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic [6:0]  opcode = 7'b0010011;
    logic        dec_write_enable = 1'b0;
    logic        dec_branch = 1'b0;
    logic        branch_taken = 1'b0;
    logic        imem_ready = 1'b0;
    logic        dmem_ready = 1'b0;
    logic        imem_req;
    logic        ir_load;
    logic        dmem_req;
    logic        dmem_rw;
    logic        regfile_we;
    logic        pc_write;
    logic [1:0]  pc_sel;
    logic [2:0]  state;
    logic        illegal_instr;
    logic        bus_error;
    logic [31:0] cycle_count;
    logic [31:0] instret_count;

    multicycle_ctrl #(.MEM_TIMEOUT(16), .CNT_WIDTH(32)) dut (
        .clock            (clock),
        .reset            (reset),
        .opcode           (opcode),
        .dec_write_enable (dec_write_enable),
        .dec_branch       (dec_branch),
        .branch_taken     (branch_taken),
        .imem_ready       (imem_ready),
        .dmem_ready       (dmem_ready),
        .imem_req         (imem_req),
        .ir_load          (ir_load),
        .dmem_req         (dmem_req),
        .dmem_rw          (dmem_rw),
        .regfile_we       (regfile_we),
        .pc_write         (pc_write),
        .pc_sel           (pc_sel),
        .state            (state),
        .illegal_instr    (illegal_instr),
        .bus_error        (bus_error),
        .cycle_count      (cycle_count),
        .instret_count    (instret_count)
    );

    always #5 clock = ~clock;

`ifdef PERF_COUNTERS_EN
    localparam bit PERF = 1'b1;
`else
    localparam bit PERF = 1'b0;
`endif

    typedef struct {
        logic        imem_rdy;
        logic        dmem_rdy;
        logic        bt;
        logic [12:0] exp;
    } step_t;

    step_t sb[$];
    int    n_pass  = 0;
    int    n_total = 0;
    string cur_tag = "";

    // Expected vector: state, {imem_req, ir_load, dmem_req, dmem_rw, regfile_we, pc_write}, pc_sel, {illegal, bus_error}
    function automatic logic [12:0] ev(input logic [2:0] st, input logic [5:0] strb,
                                       input logic [1:0] ps, input logic [1:0] flg);
        return {st, strb, ps, flg};
    endfunction

    function automatic logic [12:0] observed();
        return {state, imem_req, ir_load, dmem_req, dmem_rw, regfile_we, pc_write, pc_sel,
                illegal_instr, bus_error};
    endfunction

    task automatic push(input logic ir, input logic dr, input logic bt, input logic [12:0] e);
        step_t s;
        s.imem_rdy = ir;
        s.dmem_rdy = dr;
        s.bt       = bt;
        s.exp      = e;
        sb.push_back(s);
    endtask

    // Replays queued cycles: drive inputs, compare outputs mid-cycle, advance one clock.
    task automatic drain();
        step_t       s;
        logic [12:0] obs;
        int          idx = 0;
        while (sb.size() > 0) begin
            s = sb.pop_front();
            imem_ready   = s.imem_rdy;
            dmem_ready   = s.dmem_rdy;
            branch_taken = s.bt;
            #1;
            obs = observed();
            n_total++;
            assert (obs === s.exp) n_pass++;
            else $error("FAIL %s cyc%0d observed=%b expected=%b", cur_tag, idx, obs, s.exp);
            idx++;
            @(posedge clock);
            #1;
        end
    endtask

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    endtask

    task automatic set_instr(input string tag, input logic [6:0] op, input logic we, input logic br);
        cur_tag          = tag;
        opcode           = op;
        dec_write_enable = we;
        dec_branch       = br;
    endtask

    // Standard four-cycle ALU-style instruction with zero-wait memory.
    task automatic push_wb(input logic [1:0] ps, input logic we);
        push(1, 1, 0, ev(3'd0, 6'b110000, 2'd0, 2'b00));
        push(1, 1, 0, ev(3'd1, 6'b000000, 2'd0, 2'b00));
        push(1, 1, 0, ev(3'd2, 6'b000000, 2'd0, 2'b00));
        push(1, 1, 0, ev(3'd4, {4'b0000, we, 1'b1}, ps, 2'b00));
    endtask

    task automatic pulse_reset();
        reset = 1'b1;
        @(posedge clock);
        #1;
        reset = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog simulation time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        @(posedge clock);
        #1;
        cur_tag = "reset";
        push(1, 1, 0, ev(3'd0, 6'b000000, 2'd0, 2'b00));
        drain();
        reset = 1'b0;
        check_val("reset_cycle_count", cycle_count, 0);
        check_val("reset_instret", instret_count, 0);

        set_instr("addi", 7'b0010011, 1, 0);
        push_wb(2'd0, 1);
        drain();
        check_val("addi_instret", instret_count, PERF ? 1 : 0);
        check_val("addi_cycles", cycle_count, PERF ? 4 : 0);

        set_instr("lw_wait3", 7'b0000011, 1, 0);
        push(1, 1, 0, ev(3'd0, 6'b110000, 2'd0, 2'b00));
        push(1, 0, 0, ev(3'd1, 6'b000000, 2'd0, 2'b00));
        push(1, 0, 0, ev(3'd2, 6'b000000, 2'd0, 2'b00));
        for (int i = 0; i < 3; i++) push(1, 0, 0, ev(3'd3, 6'b001000, 2'd0, 2'b00));
        push(1, 1, 0, ev(3'd3, 6'b001000, 2'd0, 2'b00));
        push(1, 1, 0, ev(3'd4, 6'b000011, 2'd0, 2'b00));
        drain();

        set_instr("sw", 7'b0100011, 0, 0);
        push(1, 1, 0, ev(3'd0, 6'b110000, 2'd0, 2'b00));
        push(1, 1, 0, ev(3'd1, 6'b000000, 2'd0, 2'b00));
        push(1, 1, 0, ev(3'd2, 6'b000000, 2'd0, 2'b00));
        push(1, 1, 0, ev(3'd3, 6'b001101, 2'd0, 2'b00));
        drain();

        set_instr("beq_taken", 7'b1100011, 0, 1);
        push(1, 1, 1, ev(3'd0, 6'b110000, 2'd0, 2'b00));
        push(1, 1, 1, ev(3'd1, 6'b000000, 2'd0, 2'b00));
        push(1, 1, 1, ev(3'd2, 6'b000001, 2'd1, 2'b00));
        drain();

        set_instr("beq_not_taken", 7'b1100011, 0, 1);
        push(1, 1, 0, ev(3'd0, 6'b110000, 2'd0, 2'b00));
        push(1, 1, 0, ev(3'd1, 6'b000000, 2'd0, 2'b00));
        push(1, 1, 0, ev(3'd2, 6'b000001, 2'd0, 2'b00));
        drain();

        set_instr("jal", 7'b1101111, 1, 0);
        push_wb(2'd1, 1);
        drain();

        set_instr("jalr", 7'b1100111, 1, 0);
        push_wb(2'd2, 1);
        drain();

        set_instr("lui_fetch_wait", 7'b0110111, 1, 0);
        push(0, 1, 0, ev(3'd0, 6'b100000, 2'd0, 2'b00));
        push(0, 1, 0, ev(3'd0, 6'b100000, 2'd0, 2'b00));
        push_wb(2'd0, 1);
        drain();
        check_val("seq_instret", instret_count, PERF ? 8 : 0);
        check_val("seq_cycles", cycle_count, PERF ? 36 : 0);

        set_instr("illegal", 7'b1111111, 1, 0);
        push(1, 1, 0, ev(3'd0, 6'b110000, 2'd0, 2'b00));
        push(1, 1, 0, ev(3'd1, 6'b000000, 2'd0, 2'b00));
        for (int i = 0; i < 20; i++) push(1, 1, 1, ev(3'd5, 6'b000000, 2'd0, 2'b10));
        drain();
        pulse_reset();
        check_val("illegal_cleared", illegal_instr, 0);

        set_instr("addi_after_trap", 7'b0010011, 0, 0);
        push_wb(2'd0, 0);
        drain();

        set_instr("lw_timeout", 7'b0000011, 1, 0);
        push(1, 0, 0, ev(3'd0, 6'b110000, 2'd0, 2'b00));
        push(1, 0, 0, ev(3'd1, 6'b000000, 2'd0, 2'b00));
        push(1, 0, 0, ev(3'd2, 6'b000000, 2'd0, 2'b00));
        for (int i = 0; i < 16; i++) push(1, 0, 0, ev(3'd3, 6'b001000, 2'd0, 2'b00));
        for (int i = 0; i < 3; i++) push(1, 0, 0, ev(3'd5, 6'b000000, 2'd0, 2'b01));
        drain();
        pulse_reset();
        check_val("bus_error_cleared", bus_error, 0);

        set_instr("lw_reset_mid", 7'b0000011, 1, 0);
        push(1, 0, 0, ev(3'd0, 6'b110000, 2'd0, 2'b00));
        push(1, 0, 0, ev(3'd1, 6'b000000, 2'd0, 2'b00));
        push(1, 0, 0, ev(3'd2, 6'b000000, 2'd0, 2'b00));
        for (int i = 0; i < 5; i++) push(1, 0, 0, ev(3'd3, 6'b001000, 2'd0, 2'b00));
        drain();
        reset = 1'b1;
        @(posedge clock);
        #1;
        check_val("reset_mid_dmem_req", dmem_req, 0);
        check_val("reset_mid_state", state, 0);
        reset = 1'b0;

        set_instr("sw_after_reset", 7'b0100011, 0, 0);
        push(1, 1, 0, ev(3'd0, 6'b110000, 2'd0, 2'b00));
        push(1, 1, 0, ev(3'd1, 6'b000000, 2'd0, 2'b00));
        push(1, 1, 0, ev(3'd2, 6'b000000, 2'd0, 2'b00));
        push(1, 1, 0, ev(3'd3, 6'b001101, 2'd0, 2'b00));
        push(1, 1, 0, ev(3'd0, 6'b110000, 2'd0, 2'b00));
        drain();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/multicycle_ctrl.md
Name: multicycle_ctrl

Overview:
Multi-cycle sequencer for the RV32I core. It drives instruction fetch, the instruction register feeding the combinational decoder, the register-file write, data-memory handshakes and PC update, one instruction at a time. It consumes decoder outputs (opcode, write_enable, branch) and the ALU branch result. It traps on illegal opcodes and on memory timeouts.

Parameters:
MEM_TIMEOUT, 16, max cycles to wait for imem_ready/dmem_ready before bus-error trap; 0 disables timeout
CNT_WIDTH, 32, width of performance counters

Ports:
clock  input  1  system clock, rising edge
reset  input  1  synchronous, active-high reset
opcode  input  7  decoder opcode, valid from DECODE onward (IR held)
dec_write_enable  input  1  decoder write_enable
dec_branch  input  1  decoder branch flag
branch_taken  input  1  ALU compare result, valid in EXECUTE
imem_ready  input  1  instruction memory data valid
dmem_ready  input  1  data memory access complete
imem_req  output  1  fetch request
ir_load  output  1  load instruction register (1-cycle pulse)
dmem_req  output  1  data memory request
dmem_rw  output  1  0=read (load), 1=write (store)
regfile_we  output  1  register file write strobe
pc_write  output  1  PC update strobe
pc_sel  output  2  0=PC+4, 1=PC+imm (branch/JAL), 2=rs1+imm (JALR)
state  output  3  current FSM state (debug)
illegal_instr  output  1  sticky illegal-opcode flag
bus_error  output  1  sticky memory-timeout flag
cycle_count  output  CNT_WIDTH  cycles since reset
instret_count  output  CNT_WIDTH  retired instructions

Behaviour:
- Single clock domain "clock"; reset is synchronous and active-high.
- Reset: state=FETCH, all strobes/requests 0, pc_sel=0, flags 0, counters 0, wait counter 0. Reset mid-handshake drops imem_req/dmem_req on the next edge; no write is retired.
- States: FETCH=0, DECODE=1, EXECUTE=2, MEMORY=3, WRITEBACK=4, TRAP=5. Outputs are Moore or combinational from state + latched class. No strobe asserts outside its listed state.
- FETCH: imem_req=1. On imem_ready: ir_load=1 that cycle, go to DECODE.
- DECODE: one cycle. Latch instruction class from opcode (R 0110011, I 0010011, LOAD 0000011, STORE 0100011, BRANCH 1100011, JALR 1100111, JAL 1101111, AUIPC 0010111, LUI 0110111) and dec_write_enable. Any other opcode goes to TRAP with illegal_instr=1. Otherwise go to EXECUTE.
- EXECUTE: one cycle.
  - LOAD/STORE go to MEMORY.
  - BRANCH: pc_write=1, pc_sel=branch_taken?1:0, retire, go to FETCH.
  - All others go to WRITEBACK.
- MEMORY: dmem_req=1 and dmem_rw=(class==STORE), held until dmem_ready.
  - On dmem_ready, LOAD goes to WRITEBACK.
  - On dmem_ready, STORE: pc_write=1, pc_sel=0, retire, go to FETCH.
- WRITEBACK: regfile_we=latched write_enable; pc_write=1; pc_sel=1 for JAL, 2 for JALR, else 0. Retire, go to FETCH.
- TRAP: absorbing. All strobes/requests 0. Flags stay 1 until reset.
- Timeout: wait counter clears on entering FETCH/MEMORY and increments each cycle the ready is low. When MEM_TIMEOUT!=0 and the counter reaches MEM_TIMEOUT with ready still low, go to TRAP with bus_error=1. If ready arrives in that same cycle, ready wins.
- Latency with zero-wait memory: BRANCH 3 cycles; STORE 4 cycles; ALU/JAL/JALR/LUI/AUIPC 4 cycles; LOAD 5 cycles.

Optional Feature:
PERF_COUNTERS_EN
- Defined: cycle_count increments every non-reset cycle, wrapping at 2^CNT_WIDTH. instret_count increments on each retire, also wrapping. Both freeze in TRAP.
- Undefined: both ports are tied to 0 and no counter flops are built.

Decomposition:
- Package cpu_ctrl_pkg: state encoding, opcode constants, instruction-class enum, pc_sel encodings (PC_PLUS4, PC_TARGET, PC_JALR).
- Sub-module perf_counters: cycle/instret counters, instantiated only under PERF_COUNTERS_EN.
- FSM and timeout counter stay in multicycle_ctrl.

Test Plan:
- addi x1,x0,5 (opcode 0010011), imem_ready/dmem_ready tied 1 -> states 0,1,2,4,0; regfile_we=1 only in cycle 4; pc_write with pc_sel=0; instret_count=1.
- lw (0000011), dmem_ready asserted 3 cycles after MEMORY entry -> dmem_req=1, dmem_rw=0 for 4 cycles; regfile_we in WRITEBACK; 8 cycles total.
- sw (0100011), zero wait -> dmem_rw=1 in MEMORY; regfile_we never 1; pc_write in MEMORY; back to FETCH after 4 cycles.
- beq with branch_taken=1, then with 0 -> pc_sel=1, then 0, in EXECUTE; 3 cycles each; no dmem_req or regfile_we.
- opcode 7'b1111111 -> TRAP; illegal_instr=1 held 20 cycles; all strobes 0; reset pulse returns to FETCH with flag 0.
- lw with dmem_ready never asserted, MEM_TIMEOUT=16 -> TRAP with bus_error=1 after 16 wait cycles. Repeat with reset asserted at wait cycle 5 -> dmem_req=0 on next edge, state=FETCH.
